// File: rtl/gfx_pattern_gen_if.sv
// AXI4-Lite write channel bundle for the pattern generator.
// Master drives address/data/response-ready; slave answers.
interface gfx_pattern_gen_if #(
    parameter int AW = 20,
    parameter int DW = 16
);
    logic [AW-1:0]   axi_awaddr;
    logic            axi_awvalid;
    logic            axi_awready;
    logic [DW-1:0]   axi_wdata;
    logic [DW/8-1:0] axi_wstrb;
    logic            axi_wvalid;
    logic            axi_wready;
    logic            axi_bvalid;
    logic [1:0]      axi_bresp;
    logic            axi_bready;

    modport master (
        output axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb,
        output axi_wvalid, axi_bready,
        input  axi_awready, axi_wready, axi_bvalid, axi_bresp
    );

    modport slave (
        input  axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb,
        input  axi_wvalid, axi_bready,
        output axi_awready, axi_wready, axi_bvalid, axi_bresp
    );
endinterface

// File: rtl/gfx_pattern_gen.sv
// Framebuffer test-pattern filler: one AXI write per pixel,
// solid / gradient / checker / colour-bar patterns.
module gfx_pattern_gen #(
    parameter int H_VISIBLE      = 640,
    parameter int V_VISIBLE      = 480,
    parameter int PIXEL_BITS     = 12,
    parameter int AXI_ADDR_WIDTH = 20,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int CHECK_SHIFT    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic                  loop,
    input  logic [PIXEL_BITS-1:0] solid_color,
    gfx_pattern_gen_if.master     axi,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err
);
    localparam int XW    = (H_VISIBLE > 1) ? $clog2(H_VISIBLE) : 1;
    localparam int YW    = (V_VISIBLE > 1) ? $clog2(V_VISIBLE) : 1;
    localparam int BAR_W = (H_VISIBLE >= 8) ? H_VISIBLE / 8 : 1;
    localparam int BCW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int CW    = PIXEL_BITS / 3;

    localparam logic [XW-1:0]  X_MAX  = XW'(H_VISIBLE - 1);
    localparam logic [YW-1:0]  Y_MAX  = YW'(V_VISIBLE - 1);
    localparam logic [BCW-1:0] BC_MAX = BCW'(BAR_W - 1);
    localparam logic [AXI_ADDR_WIDTH-1:0] LINE_STEP =
        AXI_ADDR_WIDTH'(H_VISIBLE);

    typedef enum logic [1:0] {
        IDLE,
        ADDR_DATA,
        RESP,
        NEXT
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [XW-1:0]             r_x;
    logic [YW-1:0]             r_y;
    logic [AXI_ADDR_WIDTH-1:0] r_line_base;
    logic [2:0]                r_bar;
    logic [BCW-1:0]            r_bar_cnt;
    logic [PIXEL_BITS-1:0]     r_frame_cnt;
    logic [1:0]                r_mode;
    logic [PIXEL_BITS-1:0]     r_color;
    logic                      r_awvalid;
    logic                      r_wvalid;
    logic                      r_err;

    logic                  w_start_ok;
    logic                  w_last_x;
    logic                  w_last;
    logic                  w_aw_done;
    logic                  w_w_done;
    logic                  w_enter_ad;
    logic                  w_xb;
    logic                  w_yb;
    logic [PIXEL_BITS-1:0] w_color;

    assign w_start_ok = (r_state == IDLE) && start;
    assign w_last_x   = (r_x == X_MAX);
    assign w_last     = w_last_x && (r_y == Y_MAX);
    assign w_aw_done  = !r_awvalid || axi.axi_awready;
    assign w_w_done   = !r_wvalid || axi.axi_wready;
    assign w_enter_ad = (w_state_nxt == ADDR_DATA) &&
                        (r_state != ADDR_DATA);

    // Checker bit selects; a shift wider than the counter reads as 0.
    if (CHECK_SHIFT < XW) begin : g_xb
        assign w_xb = r_x[CHECK_SHIFT];
    end else begin : g_xb0
        assign w_xb = 1'b0;
    end
    if (CHECK_SHIFT < YW) begin : g_yb
        assign w_yb = r_y[CHECK_SHIFT];
    end else begin : g_yb0
        assign w_yb = 1'b0;
    end

    always_comb begin
        w_color = '0;
        case (r_mode)
            2'd0: w_color = r_color;
            2'd1: w_color = r_frame_cnt + PIXEL_BITS'(r_x);
            2'd2: w_color = {PIXEL_BITS{w_xb ^ w_yb}};
            2'd3: w_color = {{CW{r_bar[2]}}, {CW{r_bar[1]}},
                             {CW{r_bar[0]}}};
            default: w_color = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:      if (start) w_state_nxt = ADDR_DATA;
            ADDR_DATA: if (w_aw_done && w_w_done) w_state_nxt = RESP;
            RESP:      if (axi.axi_bvalid) w_state_nxt = NEXT;
            NEXT:      w_state_nxt = (w_last && !loop) ? IDLE : ADDR_DATA;
            default:   w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
        end else if (w_enter_ad) begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
        end else begin
            if (axi.axi_awready) r_awvalid <= 1'b0;
            if (axi.axi_wready)  r_wvalid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x         <= '0;
            r_y         <= '0;
            r_line_base <= '0;
            r_bar       <= '0;
            r_bar_cnt   <= '0;
            r_frame_cnt <= '0;
            r_mode      <= '0;
            r_color     <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_mode  <= mode;
                r_color <= solid_color;
                r_err   <= 1'b0;
            end
            if (r_state == RESP && axi.axi_bvalid &&
                axi.axi_bresp != 2'b00)
                r_err <= 1'b1;
            // Position advances only once the pixel's response is in.
            if (r_state == NEXT) begin
                if (w_last) begin
                    r_x         <= '0;
                    r_y         <= '0;
                    r_line_base <= '0;
                    r_bar       <= '0;
                    r_bar_cnt   <= '0;
                    r_frame_cnt <= r_frame_cnt + PIXEL_BITS'(1);
                end else if (w_last_x) begin
                    r_x         <= '0;
                    r_y         <= r_y + YW'(1);
                    r_line_base <= r_line_base + LINE_STEP;
                    r_bar       <= '0;
                    r_bar_cnt   <= '0;
                end else begin
                    r_x <= r_x + XW'(1);
                    if (r_bar_cnt == BC_MAX) begin
                        r_bar_cnt <= '0;
                        if (r_bar != 3'd7) r_bar <= r_bar + 3'd1;
                    end else begin
                        r_bar_cnt <= r_bar_cnt + BCW'(1);
                    end
                end
            end
        end
    end

    assign axi.axi_awaddr  = r_line_base + AXI_ADDR_WIDTH'(r_x);
    assign axi.axi_awvalid = r_awvalid;
    assign axi.axi_wdata   = AXI_DATA_WIDTH'(w_color);
    assign axi.axi_wstrb   = '1;
    assign axi.axi_wvalid  = r_wvalid;
    assign axi.axi_bready  = (r_state == RESP);

    assign busy       = (r_state != IDLE);
    assign frame_done = (r_state == NEXT) && w_last;
    assign err        = r_err;
endmodule

// File: tb/tb_gfx_pattern_gen.sv
// Scoreboard bench for gfx_pattern_gen on an 8x4 frame.
// A negedge bus agent answers AXI and logs completed writes.
module tb_gfx_pattern_gen;
    localparam int H    = 8;
    localparam int V    = 4;
    localparam int PB   = 12;
    localparam int AW   = 20;
    localparam int DW   = 16;
    localparam int CS   = 1;
    localparam int NPIX = H * V;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          loop = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [PB-1:0] solid_color = '0;
    logic          busy;
    logic          frame_done;
    logic          err;

    gfx_pattern_gen_if #(.AW(AW), .DW(DW)) bus ();

    gfx_pattern_gen #(
        .H_VISIBLE(H), .V_VISIBLE(V), .PIXEL_BITS(PB),
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .CHECK_SHIFT(CS)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .loop(loop), .solid_color(solid_color), .axi(bus),
        .busy(busy), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int aw_delay = 0;
    int err_idx = -1;
    int resp_idx = 0;
    int fd_count = 0;
    int busy_cyc = 0;
    int aw_wait = 0;
    int w_cyc = 0;
    int last_aw_cycles = 0;
    int last_w_cycles = 0;
    int aw_unstable = 0;
    logic          aw_got = 1'b0;
    logic          w_got = 1'b0;
    logic [AW-1:0] aw_c, aw_hold;
    logic [DW-1:0] w_c;
    logic [AW-1:0] obs_a[$];
    logic [AW-1:0] exp_a[$];
    logic [DW-1:0] obs_d[$];
    logic [DW-1:0] exp_d[$];

    // Inputs change at negedge; what is set here meets the DUT at the next posedge.
    initial begin
        bus.axi_awready = 1'b0;
        bus.axi_wready  = 1'b0;
        bus.axi_bvalid  = 1'b0;
        bus.axi_bresp   = 2'b00;
        forever begin
            @(negedge clk);
            if (reset) begin
                bus.axi_awready = 1'b0;
                bus.axi_wready  = 1'b0;
                bus.axi_bvalid  = 1'b0;
                bus.axi_bresp   = 2'b00;
                aw_got = 1'b0;
                w_got  = 1'b0;
                aw_wait = 0;
                w_cyc = 0;
            end else begin
                if (frame_done) fd_count++;
                if (busy) busy_cyc++;
                if (bus.axi_awvalid) begin
                    if (aw_wait > 0 && bus.axi_awaddr !== aw_hold)
                        aw_unstable++;
                    aw_hold = bus.axi_awaddr;
                    bus.axi_awready = (aw_wait >= aw_delay);
                    aw_wait++;
                    if (bus.axi_awready) begin
                        aw_got = 1'b1;
                        aw_c = bus.axi_awaddr;
                        last_aw_cycles = aw_wait;
                        aw_wait = 0;
                    end
                end else begin
                    bus.axi_awready = (aw_delay == 0);
                end
                bus.axi_wready = 1'b1;
                if (bus.axi_wvalid) begin
                    w_cyc++;
                    w_got = 1'b1;
                    w_c = bus.axi_wdata;
                    last_w_cycles = w_cyc;
                    w_cyc = 0;
                end
                if (bus.axi_bready) begin
                    bus.axi_bvalid = 1'b1;
                    bus.axi_bresp = (resp_idx == err_idx) ? 2'd2 : 2'd0;
                    resp_idx++;
                end else begin
                    bus.axi_bvalid = 1'b0;
                    bus.axi_bresp = 2'd0;
                end
                if (aw_got && w_got) begin
                    obs_a.push_back(aw_c);
                    obs_d.push_back(w_c);
                    aw_got = 1'b0;
                    w_got = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    task automatic pulse_start();
        @(negedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_write(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (obs_a.size() > 0) begin
                ok = 1'b1;
                return;
            end
            @(posedge clk);
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic clear_queues();
        obs_a.delete();
        obs_d.delete();
        exp_a.delete();
        exp_d.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total += 8;
        if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (bus.axi_awvalid !== 1'b0) begin bad++; $display("FAIL rst_awvalid: got %b want 0", bus.axi_awvalid); end
        if (bus.axi_wvalid !== 1'b0) begin bad++; $display("FAIL rst_wvalid: got %b want 0", bus.axi_wvalid); end
        if (bus.axi_bready !== 1'b0) begin bad++; $display("FAIL rst_bready: got %b want 0", bus.axi_bready); end
        if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
        if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err); end
        if (bus.axi_awaddr !== '0) begin bad++; $display("FAIL rst_awaddr: got %h want 0", bus.axi_awaddr); end
        if (bus.axi_wdata !== '0) begin bad++; $display("FAIL rst_wdata: got %h want 0", bus.axi_wdata); end
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy: got %b want 0", busy); end
    endtask

    task automatic test_solid();
        bit ok;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        clear_queues();
        mode = 2'd0; solid_color = 12'hABC; loop = 1'b0;
        for (int i = 0; i < NPIX; i++) begin
            exp_a.push_back(AW'(i));
            exp_d.push_back(16'h0ABC);
        end
        fd_count = 0; resp_idx = 0; busy_cyc = 0;
        pulse_start();
        for (int i = 0; i < NPIX; i++) begin
            wait_write(ok);
            total++;
            if (!ok) begin bad++; $display("FAIL solid_timeout: pixel %0d missing, want a write", i); break; end
            a = obs_a.pop_front(); d = obs_d.pop_front();
            total += 2;
            if (a !== exp_a[0]) begin bad++; $display("FAIL solid_addr[%0d]: got %h want %h", i, a, exp_a[0]); end
            if (d !== exp_d[0]) begin bad++; $display("FAIL solid_data[%0d]: got %h want %h", i, d, exp_d[0]); end
            void'(exp_a.pop_front()); void'(exp_d.pop_front());
        end
        wait_idle(ok);
        repeat (10) @(negedge clk);
        total += 5;
        if (!ok) begin bad++; $display("FAIL solid_busy_fall: busy=%b want 0", busy); end
        if (fd_count != 1) begin bad++; $display("FAIL solid_frame_done: got %0d pulses want 1", fd_count); end
        if (busy_cyc != 3 * NPIX) begin bad++; $display("FAIL solid_cycles: busy %0d cycles want %0d", busy_cyc, 3 * NPIX); end
        if (obs_a.size() != 0) begin bad++; $display("FAIL solid_extra: %0d extra writes want 0", obs_a.size()); end
        if (err !== 1'b0) begin bad++; $display("FAIL solid_err: got %b want 0", err); end
    endtask

    task automatic test_bars();
        bit ok;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int v;
        clear_queues();
        mode = 2'd3; loop = 1'b0;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) begin
                v = ((x & 4) != 0 ? 32'hF00 : 0) | ((x & 2) != 0 ? 32'h0F0 : 0) |
                    ((x & 1) != 0 ? 32'h00F : 0);
                exp_a.push_back(AW'(y * H + x));
                exp_d.push_back(DW'(v));
            end
        fd_count = 0; resp_idx = 0;
        pulse_start();
        for (int i = 0; i < NPIX; i++) begin
            wait_write(ok);
            total++;
            if (!ok) begin bad++; $display("FAIL bars_timeout: pixel %0d missing, want a write", i); break; end
            a = obs_a.pop_front(); d = obs_d.pop_front();
            total += 2;
            if (a !== exp_a[0]) begin bad++; $display("FAIL bars_addr[%0d]: got %h want %h", i, a, exp_a[0]); end
            if (d !== exp_d[0]) begin bad++; $display("FAIL bars_data[%0d]: got %h want %h", i, d, exp_d[0]); end
            void'(exp_a.pop_front()); void'(exp_d.pop_front());
        end
        wait_idle(ok);
        total += 2;
        if (!ok) begin bad++; $display("FAIL bars_busy_fall: busy=%b want 0", busy); end
        if (fd_count != 1) begin bad++; $display("FAIL bars_frame_done: got %0d want 1", fd_count); end
    endtask

    task automatic test_checker();
        bit ok;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        clear_queues();
        mode = 2'd2; loop = 1'b0;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) begin
                exp_a.push_back(AW'(y * H + x));
                exp_d.push_back((((x >> CS) ^ (y >> CS)) & 1) != 0 ? 16'h0FFF : 16'h0000);
            end
        fd_count = 0; resp_idx = 0;
        pulse_start();
        for (int i = 0; i < NPIX; i++) begin
            wait_write(ok);
            total++;
            if (!ok) begin bad++; $display("FAIL chk_timeout: pixel %0d missing, want a write", i); break; end
            a = obs_a.pop_front(); d = obs_d.pop_front();
            total += 2;
            if (a !== exp_a[0]) begin bad++; $display("FAIL chk_addr[%0d]: got %h want %h", i, a, exp_a[0]); end
            if (d !== exp_d[0]) begin bad++; $display("FAIL chk_data[%0d]: got %h want %h", i, d, exp_d[0]); end
            void'(exp_a.pop_front()); void'(exp_d.pop_front());
        end
        wait_idle(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL chk_busy_fall: busy=%b want 0", busy); end
    endtask

    task automatic test_gradient_loop();
        bit ok;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
        clear_queues();
        mode = 2'd1; loop = 1'b1;
        for (int f = 0; f < 2; f++)
            for (int y = 0; y < V; y++)
                for (int x = 0; x < H; x++) begin
                    exp_a.push_back(AW'(y * H + x));
                    exp_d.push_back(DW'((x + f) & 12'hFFF));
                end
        fd_count = 0; resp_idx = 0;
        pulse_start();
        mode = 2'd2;
        for (int i = 0; i < 2 * NPIX; i++) begin
            wait_write(ok);
            total++;
            if (!ok) begin bad++; $display("FAIL grad_timeout: pixel %0d missing, want a write", i); break; end
            a = obs_a.pop_front(); d = obs_d.pop_front();
            total += 2;
            if (a !== exp_a[0]) begin bad++; $display("FAIL grad_addr[%0d]: got %h want %h", i, a, exp_a[0]); end
            if (d !== exp_d[0]) begin bad++; $display("FAIL grad_data[%0d]: got %h want %h", i, d, exp_d[0]); end
            void'(exp_a.pop_front()); void'(exp_d.pop_front());
            if (i == 40) loop = 1'b0;
        end
        wait_idle(ok);
        repeat (10) @(negedge clk);
        total += 3;
        if (!ok) begin bad++; $display("FAIL grad_busy_fall: busy=%b want 0", busy); end
        if (fd_count != 2) begin bad++; $display("FAIL grad_frame_done: got %0d pulses want 2", fd_count); end
        if (obs_a.size() != 0) begin bad++; $display("FAIL grad_extra: %0d extra writes want 0", obs_a.size()); end
    endtask

    task automatic test_backpressure_err();
        bit ok;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        clear_queues();
        mode = 2'd0; solid_color = 12'h123; loop = 1'b0;
        aw_delay = 3; err_idx = 5; aw_unstable = 0;
        for (int i = 0; i < NPIX; i++) begin
            exp_a.push_back(AW'(i));
            exp_d.push_back(16'h0123);
        end
        fd_count = 0; resp_idx = 0;
        pulse_start();
        for (int i = 0; i < NPIX; i++) begin
            wait_write(ok);
            total++;
            if (!ok) begin bad++; $display("FAIL bp_timeout: pixel %0d missing, want a write", i); break; end
            a = obs_a.pop_front(); d = obs_d.pop_front();
            total += 2;
            if (a !== exp_a[0]) begin bad++; $display("FAIL bp_addr[%0d]: got %h want %h", i, a, exp_a[0]); end
            if (d !== exp_d[0]) begin bad++; $display("FAIL bp_data[%0d]: got %h want %h", i, d, exp_d[0]); end
            void'(exp_a.pop_front()); void'(exp_d.pop_front());
            if (i == 0) begin
                total += 2;
                if (last_aw_cycles != 4) begin bad++; $display("FAIL bp_aw_hold: awvalid %0d cycles want 4", last_aw_cycles); end
                if (last_w_cycles != 1) begin bad++; $display("FAIL bp_w_drop: wvalid %0d cycles want 1", last_w_cycles); end
            end
            if (i == 3) begin
                total++;
                if (err !== 1'b0) begin bad++; $display("FAIL bp_err_early: got %b want 0", err); end
            end
            if (i == 10) begin
                total++;
                if (err !== 1'b1) begin bad++; $display("FAIL bp_err_set: got %b want 1", err); end
            end
        end
        wait_idle(ok);
        repeat (10) @(negedge clk);
        total += 4;
        if (!ok) begin bad++; $display("FAIL bp_busy_fall: busy=%b want 0", busy); end
        if (err !== 1'b1) begin bad++; $display("FAIL bp_err_sticky: got %b want 1", err); end
        if (aw_unstable != 0) begin bad++; $display("FAIL bp_addr_stable: %0d changes want 0", aw_unstable); end
        if (obs_a.size() != 0) begin bad++; $display("FAIL bp_extra: %0d extra writes want 0", obs_a.size()); end
        aw_delay = 0; err_idx = -1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        clear_queues();
        mode = 2'd0; solid_color = 12'h555; loop = 1'b0; aw_delay = 3;
        for (int i = 0; i < 2; i++) begin
            exp_a.push_back(AW'(i));
            exp_d.push_back(16'h0555);
        end
        fd_count = 0; resp_idx = 0;
        pulse_start();
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL mid_start_clears_err: got %b want 0", err); end
        for (int i = 0; i < 2; i++) begin
            wait_write(ok);
            total++;
            if (!ok) begin bad++; $display("FAIL mid_pre_timeout: pixel %0d missing, want a write", i); break; end
            a = obs_a.pop_front(); d = obs_d.pop_front();
            total++;
            if (a !== exp_a[0] || d !== exp_d[0]) begin bad++; $display("FAIL mid_pre[%0d]: got %h/%h want %h/%h", i, a, d, exp_a[0], exp_d[0]); end
            void'(exp_a.pop_front()); void'(exp_d.pop_front());
        end
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.axi_awvalid) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) begin bad++; $display("FAIL mid_awvalid_wait: awvalid=%b want 1", bus.axi_awvalid); end
        #3 reset = 1'b1;
        #1;
        total += 4;
        if (bus.axi_awvalid !== 1'b0) begin bad++; $display("FAIL mid_async_awvalid: got %b want 0", bus.axi_awvalid); end
        if (bus.axi_wvalid !== 1'b0) begin bad++; $display("FAIL mid_async_wvalid: got %b want 0", bus.axi_wvalid); end
        if (busy !== 1'b0) begin bad++; $display("FAIL mid_async_busy: got %b want 0", busy); end
        if (bus.axi_awaddr !== '0) begin bad++; $display("FAIL mid_async_awaddr: got %h want 0", bus.axi_awaddr); end
        @(negedge clk);
        #1 reset = 1'b0;
        aw_delay = 0;
        clear_queues();
        solid_color = 12'h321;
        for (int i = 0; i < NPIX; i++) begin
            exp_a.push_back(AW'(i));
            exp_d.push_back(16'h0321);
        end
        fd_count = 0; resp_idx = 0;
        pulse_start();
        for (int i = 0; i < NPIX; i++) begin
            wait_write(ok);
            total++;
            if (!ok) begin bad++; $display("FAIL mid_timeout: pixel %0d missing, want a write", i); break; end
            a = obs_a.pop_front(); d = obs_d.pop_front();
            total += 2;
            if (a !== exp_a[0]) begin bad++; $display("FAIL mid_addr[%0d]: got %h want %h", i, a, exp_a[0]); end
            if (d !== exp_d[0]) begin bad++; $display("FAIL mid_data[%0d]: got %h want %h", i, d, exp_d[0]); end
            void'(exp_a.pop_front()); void'(exp_d.pop_front());
            if (i == 5) begin
                @(negedge clk);
                #1 start = 1'b1; solid_color = 12'h777; mode = 2'd3;
                @(negedge clk);
                #1 start = 1'b0;
            end
        end
        wait_idle(ok);
        repeat (10) @(negedge clk);
        total += 4;
        if (!ok) begin bad++; $display("FAIL mid_busy_fall: busy=%b want 0", busy); end
        if (fd_count != 1) begin bad++; $display("FAIL mid_frame_done: got %0d want 1", fd_count); end
        if (obs_a.size() != 0) begin bad++; $display("FAIL mid_extra: %0d extra writes want 0", obs_a.size()); end
        if (err !== 1'b0) begin bad++; $display("FAIL mid_err: got %b want 0", err); end
    endtask

    initial begin
        test_reset();
        test_solid();
        test_bars();
        test_checker();
        test_gradient_loop();
        test_backpressure_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gfx_pattern_gen.md
GFX_PATTERN_GEN -- requirements
Module: gfx_pattern_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, meaning pixels per line.
REQ-002 SHALL have parameter V_VISIBLE, default 480, meaning lines per frame.
REQ-003 SHALL have parameter PIXEL_BITS, default 12, meaning color width; it must be a multiple of 3 and ≤ AXI_DATA_WIDTH.
REQ-004 SHALL have parameter AXI_ADDR_WIDTH, default 20, meaning framebuffer address width.
REQ-005 SHALL have parameter AXI_DATA_WIDTH, default 16, meaning write data width.
REQ-006 SHALL have parameter CHECK_SHIFT, default 4, meaning log2 of the checkerboard square size.
REQ-007 SHALL have port clk, input, 1, the single clock.
REQ-008 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-009 SHALL have port start, input, 1, a one-cycle request to begin a fill.
REQ-010 SHALL have port mode, input, 2: 0 solid, 1 gradient, 2 checker, 3 bars.
REQ-011 SHALL have port loop, input, 1, meaning repeat frames continuously.
REQ-012 SHALL have port solid_color, input, PIXEL_BITS, the color used by mode 0.
REQ-013 SHALL have ports axi_awaddr (output, AXI_ADDR_WIDTH), axi_awvalid (output, 1) and axi_awready (input, 1).
REQ-014 SHALL have ports axi_wdata (output, AXI_DATA_WIDTH), axi_wstrb (output, AXI_DATA_WIDTH/8), axi_wvalid (output, 1) and axi_wready (input, 1).
REQ-015 SHALL have ports axi_bvalid (input, 1), axi_bresp (input, 2) and axi_bready (output, 1).
REQ-016 SHALL have ports busy (output, 1), frame_done (output, 1, one-cycle pulse) and err (output, 1, sticky).

Function
REQ-017 SHALL implement states IDLE, ADDR_DATA, RESP and NEXT.
- IDLE→ADDR_DATA on start.
- ADDR_DATA→RESP when both AW and W have been accepted.
- RESP→NEXT on bvalid&&bready.
- NEXT→ADDR_DATA for the next pixel, or IDLE at frame end.
REQ-018 SHALL latch mode and solid_color on start; changes during a frame are ignored until the next start.
REQ-019 SHALL ignore start while busy=1.
REQ-020 SHALL assert busy whenever the state is not IDLE.
REQ-021 SHALL assert axi_awvalid and axi_wvalid together on entry to ADDR_DATA.
- Each valid deasserts independently on the cycle after its own handshake (valid&&ready).
- Payloads stay stable while the corresponding valid is high.
REQ-022 SHALL assert axi_bready only in RESP.
REQ-023 SHALL drive axi_awaddr = y*H_VISIBLE + x, truncated to AXI_ADDR_WIDTH; the multiply is replaced by a running line-base register.
REQ-024 SHALL drive axi_wdata = pixel color zero-extended to AXI_DATA_WIDTH, and axi_wstrb = all ones.
REQ-025 SHALL compute pixel color as follows:
- Mode 0: solid_color.
- Mode 1: (x + frame_cnt) mod 2^PIXEL_BITS.
- Mode 2: all-ones if bit 0 of ((x>>CHECK_SHIFT) ^ (y>>CHECK_SHIFT)) is 1, else 0.
- Mode 3: bar index b = floor(x / (H_VISIBLE/8)), clamped to 7. Red channel is all-ones when b[2]=1, green when b[1]=1, blue when b[0]=1, otherwise 0. b comes from a per-line bar counter; no divider.
REQ-026 SHALL have x count 0..H_VISIBLE-1, and wrap to 0 with y+1 after the last pixel of a line.
REQ-027 SHALL treat pixel (H_VISIBLE-1, V_VISIBLE-1) as frame end.
- At frame end, pulse frame_done for exactly one cycle in NEXT.
- Increment frame_cnt (PIXEL_BITS wide, wrapping).
- Reset x and y to 0.
REQ-028 SHALL sample loop in NEXT at frame end: 1 → continue with a new frame (same latched mode); 0 → IDLE.
REQ-029 SHALL set err sticky to 1 on any response with axi_bresp≠0; writing continues; err is cleared only by start or reset.
REQ-030 SHALL produce exactly one write per pixel, with at most one outstanding transaction.
REQ-031 SHALL make the minimum per-pixel time 3 cycles when awready=wready=bvalid=1 continuously.

Reset
REQ-032 SHALL, on reset assertion (asynchronously, including mid-transaction):
- force IDLE;
- set axi_awvalid=axi_wvalid=axi_bready=0;
- set busy=0, frame_done=0, err=0;
- set x=y=0, frame_cnt=0;
- set axi_awaddr=0 and axi_wdata=0.
REQ-033 SHALL accept no start until reset has been deasserted and a rising clk edge has occurred.

Verification
REQ-034 SHALL cover: H=8, V=4, mode 0, solid_color=0xABC, ready/bvalid always 1 → 32 writes to addresses 0..31, all with data 0x0ABC; one frame_done; busy falls afterwards.
REQ-035 SHALL cover: H=8, V=4, mode 3 → data at x=0..7 is 0x000, 0x00F, 0x0F0, 0x0FF, 0xF00, 0xF0F, 0xFF0, 0xFFF on every line.
REQ-036 SHALL cover: H=8, V=4, CHECK_SHIFT=1, mode 2 → line 0 reads 0,0,FFF,FFF,0,0,FFF,FFF; line 2 is inverted.
REQ-037 SHALL cover: mode 1 with loop=1 for 2 frames → frame 1 pixel x=3 has data 4; two frame_done pulses; loop dropped → IDLE after the second frame.
REQ-038 SHALL cover: awready delayed 3 cycles while wready=1 → wvalid drops after 1 cycle, awvalid holds with stable address, and exactly one write results; bresp=2 on pixel 5 → err=1 and persists.
REQ-039 SHALL cover: reset asserted mid-ADDR_DATA → awvalid=0 immediately (asynchronous); next start begins at address 0; a start issued while busy has no effect.
